t08_lcd_sequencer: RTL and testbench

- Controller in front of the team's 8080-style LCD command/parameter serializer (enable_command / enable_parameter / busy interface).
- After reset it runs a fixed power-up command sequence into the serializer.
- It then accepts rectangle-fill requests and breaks each one into CASET, PASET, RAMWR and per-pixel write-continue transactions, one transaction at a time.
- When RAW_CMD_EN is defined, it also arbitrates a raw command requester against fill requests.

---
 rtl/t08_lcd_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_t08_lcd_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t08_lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : t08_lcd_sequencer
// Purpose  : Power-up and rectangle-fill sequencer in front of the 8080-style
//            LCD command/parameter serializer. RAW_CMD_EN adds a raw command
//            requester that takes priority over fills.
// Revision : 1.0 - initial release
// ============================================================================
module t08_lcd_sequencer #(
   parameter logic [7:0] MADCTL_VAL   = 8'h48,
   parameter logic [7:0] COLMOD_VAL   = 8'h55,
   parameter int         BUSY_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        fill_valid,
   output logic        fill_ready,
   input  logic [8:0]  fill_x0,
   input  logic [8:0]  fill_x1,
   input  logic [8:0]  fill_y0,
   input  logic [8:0]  fill_y1,
   input  logic [15:0] fill_color,
`ifdef RAW_CMD_EN
   input  logic        raw_valid,
   output logic        raw_ready,
   input  logic [7:0]  raw_cmd,
   input  logic [3:0]  raw_cnt,
   input  logic [31:0] raw_par,
`endif
   output logic [31:0] spi_inputs,
   output logic        spi_enable_command,
   output logic        spi_enable_parameter,
   input  logic        spi_busy,
   output logic        init_done,
   output logic        fill_err,
   output logic        timeout_err
);

   localparam int                  c_wait_w    = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      M_INIT, M_IDLE, M_ERR, M_CASET, M_PASET, M_PIX, M_RAW
   } main_t;

   typedef enum logic [2:0] {
      P_ISSUE, P_CMD, P_PAR, P_WHI, P_WLO
   } phase_t;

   main_t               r_main, w_main_nx;
   phase_t              r_phase, w_phase_nx;
   logic                r_arm;
   logic [2:0]          r_rom_idx, w_rom_nx;
   logic [c_wait_w-1:0] r_wait, w_wait_nx;
   logic [17:0]         r_pix_cnt, w_pix_nx, w_dx, w_dy, w_n;
   logic                r_first, w_first_nx;
   logic [8:0]          r_x0, r_x1, r_y0, r_y1;
   logic [15:0]         r_color;
   logic [31:0]         r_data, w_data_nx;
   logic                r_cmd_stb, w_cmd_stb_nx, r_par_stb, w_par_stb_nx;
   logic                r_init_done, w_done_nx, r_fill_err, w_ferr_nx, r_timeout, w_tout_nx;
   logic [7:0]          w_cmd;
   logic [3:0]          w_cnt;
   logic [31:0]         w_par;
   logic                w_idle_ok, w_fill_go, w_bad, w_raw_go;

`ifdef RAW_CMD_EN
   logic [7:0]          r_raw_cmd;
   logic [3:0]          r_raw_cnt;
   logic [31:0]         r_raw_par;

   assign raw_ready  = w_idle_ok;
   assign w_raw_go   = raw_valid && w_idle_ok;
   assign fill_ready = w_idle_ok && !r_timeout && !raw_valid;
`else
   assign w_raw_go   = 1'b0;
   assign fill_ready = w_idle_ok && !r_timeout;
`endif

   assign w_idle_ok = (r_main == M_IDLE) && r_init_done;
   assign w_fill_go = fill_valid && fill_ready;
   assign w_bad     = (fill_x1 < fill_x0) || (fill_y1 < fill_y0);

   assign w_dx = 18'(r_x1) - 18'(r_x0) + 18'd1;
   assign w_dy = 18'(r_y1) - 18'(r_y0) + 18'd1;
   assign w_n  = w_dx * w_dy;

   assign spi_inputs           = r_data;
   assign spi_enable_command   = r_cmd_stb;
   assign spi_enable_parameter = r_par_stb;
   assign init_done            = r_init_done;
   assign fill_err             = r_fill_err;
   assign timeout_err          = r_timeout;

   // Command, parameter count and packed parameter for the current job step
   always_comb begin
      w_cmd = 8'h00;
      w_cnt = 4'd0;
      w_par = 32'd0;
      case (r_main)
         M_INIT: begin
            case (r_rom_idx)
               3'd0: w_cmd = 8'h01;
               3'd1: w_cmd = 8'h11;
               3'd2: begin w_cmd = 8'h3A; w_cnt = 4'd1; w_par = {COLMOD_VAL, 24'd0}; end
               3'd3: begin w_cmd = 8'h36; w_cnt = 4'd1; w_par = {MADCTL_VAL, 24'd0}; end
               default: w_cmd = 8'h29;
            endcase
         end
         M_CASET: begin w_cmd = 8'h2A; w_cnt = 4'd4; w_par = {7'd0, r_x0, 7'd0, r_x1}; end
         M_PASET: begin w_cmd = 8'h2B; w_cnt = 4'd4; w_par = {7'd0, r_y0, 7'd0, r_y1}; end
         M_PIX: begin
            w_cmd = r_first ? 8'h2C : 8'h3C;
            w_cnt = 4'd2;
            w_par = {r_color, 16'd0};
         end
`ifdef RAW_CMD_EN
         M_RAW: begin w_cmd = r_raw_cmd; w_cnt = r_raw_cnt; w_par = r_raw_par; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_main_nx    = r_main;
      w_phase_nx   = r_phase;
      w_rom_nx     = r_rom_idx;
      w_wait_nx    = r_wait;
      w_pix_nx     = r_pix_cnt;
      w_first_nx   = r_first;
      w_data_nx    = r_data;
      w_cmd_stb_nx = 1'b0;
      w_par_stb_nx = 1'b0;
      w_done_nx    = r_init_done;
      w_ferr_nx    = 1'b0;
      w_tout_nx    = r_timeout;
      if (r_main == M_CASET) w_pix_nx = w_n;
      case (r_main)
         M_IDLE: begin
            if (w_raw_go) begin
               w_main_nx = M_RAW;
            end else if (w_fill_go) begin
               w_ferr_nx = w_bad;
               if (w_bad) w_main_nx = M_ERR;
               else       w_main_nx = M_CASET;
            end
         end
         M_ERR: w_main_nx = M_IDLE;
         M_INIT, M_CASET, M_PASET, M_PIX, M_RAW: begin
            case (r_phase)
               P_ISSUE: begin
                  // r_arm keeps the first strobe out of the cycle after reset release
                  if (r_arm) begin
                     w_phase_nx   = P_CMD;
                     w_cmd_stb_nx = 1'b1;
                     w_data_nx    = {20'd0, w_cnt, w_cmd};
                  end
               end
               P_CMD: begin
                  w_phase_nx   = P_PAR;
                  w_par_stb_nx = 1'b1;
                  w_data_nx    = w_par;
               end
               P_PAR: begin
                  w_phase_nx = P_WHI;
                  w_wait_nx  = '0;
               end
               P_WHI: begin
                  if (spi_busy) begin
                     w_phase_nx = P_WLO;
                  end else if (r_wait == c_wait_last) begin
                     w_tout_nx  = 1'b1;
                     w_main_nx  = M_IDLE;
                     w_phase_nx = P_ISSUE;
                  end else begin
                     w_wait_nx = r_wait + c_wait_w'(1);
                  end
               end
               P_WLO: begin
                  if (!spi_busy) begin
                     w_phase_nx = P_ISSUE;
                     case (r_main)
                        M_INIT: begin
                           if (r_rom_idx == 3'd4) begin
                              w_done_nx = 1'b1;
                              w_main_nx = M_IDLE;
                           end else begin
                              w_rom_nx = r_rom_idx + 3'd1;
                           end
                        end
                        M_CASET: w_main_nx = M_PASET;
                        M_PASET: begin
                           w_main_nx  = M_PIX;
                           w_first_nx = 1'b1;
                        end
                        M_PIX: begin
                           w_first_nx = 1'b0;
                           w_pix_nx   = r_pix_cnt - 18'd1;
                           if (r_pix_cnt == 18'd1) w_main_nx = M_IDLE;
                        end
                        default: w_main_nx = M_IDLE;
                     endcase
                  end
               end
               default: w_phase_nx = P_ISSUE;
            endcase
         end
         default: w_main_nx = M_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_main      <= M_INIT;
         r_phase     <= P_ISSUE;
         r_arm       <= 1'b0;
         r_rom_idx   <= '0;
         r_wait      <= '0;
         r_pix_cnt   <= '0;
         r_first     <= 1'b0;
         r_x0        <= '0;
         r_x1        <= '0;
         r_y0        <= '0;
         r_y1        <= '0;
         r_color     <= '0;
         r_data      <= '0;
         r_cmd_stb   <= 1'b0;
         r_par_stb   <= 1'b0;
         r_init_done <= 1'b0;
         r_fill_err  <= 1'b0;
         r_timeout   <= 1'b0;
`ifdef RAW_CMD_EN
         r_raw_cmd   <= '0;
         r_raw_cnt   <= '0;
         r_raw_par   <= '0;
`endif
      end else begin
         r_main      <= w_main_nx;
         r_phase     <= w_phase_nx;
         r_arm       <= 1'b1;
         r_rom_idx   <= w_rom_nx;
         r_wait      <= w_wait_nx;
         r_pix_cnt   <= w_pix_nx;
         r_first     <= w_first_nx;
         r_data      <= w_data_nx;
         r_cmd_stb   <= w_cmd_stb_nx;
         r_par_stb   <= w_par_stb_nx;
         r_init_done <= w_done_nx;
         r_fill_err  <= w_ferr_nx;
         r_timeout   <= w_tout_nx;
         if (w_fill_go) begin
            r_x0    <= fill_x0;
            r_x1    <= fill_x1;
            r_y0    <= fill_y0;
            r_y1    <= fill_y1;
            r_color <= fill_color;
         end
`ifdef RAW_CMD_EN
         if (w_raw_go) begin
            r_raw_cmd <= raw_cmd;
            r_raw_cnt <= raw_cnt;
            r_raw_par <= raw_par;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_t08_lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_t08_lcd_sequencer
// Purpose  : Self-checking bench for t08_lcd_sequencer with a serializer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t08_lcd_sequencer;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        fill_valid = 1'b0;
   logic        fill_ready;
   logic [8:0]  fill_x0 = '0, fill_x1 = '0, fill_y0 = '0, fill_y1 = '0;
   logic [15:0] fill_color = '0;
   logic [31:0] spi_inputs;
   logic        spi_enable_command, spi_enable_parameter;
   logic        spi_busy;
   logic        init_done, fill_err, timeout_err;
`ifdef RAW_CMD_EN
   logic        raw_valid = 1'b0;
   logic        raw_ready;
   logic [7:0]  raw_cmd = '0;
   logic [3:0]  raw_cnt = '0;
   logic [31:0] raw_par = '0;
`endif

   always #5 clk = ~clk;

   t08_lcd_sequencer dut (
      .clk                  (clk),
      .nrst                 (nrst),
      .fill_valid           (fill_valid),
      .fill_ready           (fill_ready),
      .fill_x0              (fill_x0),
      .fill_x1              (fill_x1),
      .fill_y0              (fill_y0),
      .fill_y1              (fill_y1),
      .fill_color           (fill_color),
`ifdef RAW_CMD_EN
      .raw_valid            (raw_valid),
      .raw_ready            (raw_ready),
      .raw_cmd              (raw_cmd),
      .raw_cnt              (raw_cnt),
      .raw_par              (raw_par),
`endif
      .spi_inputs           (spi_inputs),
      .spi_enable_command   (spi_enable_command),
      .spi_enable_parameter (spi_enable_parameter),
      .spi_busy             (spi_busy),
      .init_done            (init_done),
      .fill_err             (fill_err),
      .timeout_err          (timeout_err)
   );

   // Serializer model: busy rises the cycle after a parameter strobe, holds 10 cycles
   logic model_dead = 1'b0;
   int   busy_left;
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         spi_busy  <= 1'b0;
         busy_left <= 0;
      end else if (spi_enable_parameter && !model_dead) begin
         spi_busy  <= 1'b1;
         busy_left <= 10;
      end else if (busy_left > 1) begin
         busy_left <= busy_left - 1;
      end else if (busy_left == 1) begin
         busy_left <= 0;
         spi_busy  <= 1'b0;
      end
   end

   typedef struct packed {
      logic [7:0]  cmd;
      logic [3:0]  cnt;
      logic [31:0] par;
   } txn_t;

   txn_t q[$];
   txn_t eq[$];
   txn_t cur;
   logic cur_ok = 1'b0;
   int   fill_err_pulses = 0;
   int   hdr_bad = 0;
   int   orphan = 0;
   int   checks = 0;
   int   errors = 0;

   always @(negedge clk) begin
      if (nrst) begin
         if (spi_enable_command) begin
            cur.cmd = spi_inputs[7:0];
            cur.cnt = spi_inputs[11:8];
            cur_ok  = 1'b1;
            if (spi_inputs[31:12] != 20'd0) hdr_bad++;
         end
         if (spi_enable_parameter) begin
            cur.par = spi_inputs;
            if (cur_ok) q.push_back(cur);
            else        orphan++;
            cur_ok = 1'b0;
         end
         if (fill_err) fill_err_pulses++;
      end else begin
         cur_ok = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] c, input logic [3:0] n, input logic [31:0] p);
      txn_t t;
      t.cmd = c;
      t.cnt = n;
      t.par = p;
      eq.push_back(t);
   endtask

   task automatic exp_init();
      push_exp(8'h01, 4'd0, 32'h0);
      push_exp(8'h11, 4'd0, 32'h0);
      push_exp(8'h3A, 4'd1, 32'h55000000);
      push_exp(8'h36, 4'd1, 32'h48000000);
      push_exp(8'h29, 4'd0, 32'h0);
   endtask

   task automatic exp_fill(input logic [8:0] x0, x1, y0, y1, input logic [15:0] col);
      int n;
      n = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
      push_exp(8'h2A, 4'd4, {7'd0, x0, 7'd0, x1});
      push_exp(8'h2B, 4'd4, {7'd0, y0, 7'd0, y1});
      push_exp(8'h2C, 4'd2, {col, 16'd0});
      for (int k = 1; k < n; k++) push_exp(8'h3C, 4'd2, {col, 16'd0});
   endtask

   task automatic compare_q(input string tag);
      int n;
      chk($sformatf("%s txn count", tag), q.size(), eq.size());
      n = (q.size() < eq.size()) ? q.size() : eq.size();
      for (int k = 0; k < n; k++)
         chk($sformatf("%s txn[%0d] cmd/cnt/par", tag, k), q[k], eq[k]);
   endtask

   task automatic wait_ready(input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (fill_ready) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_init(input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (init_done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic set_fill(input logic [8:0] x0, x1, y0, y1, input logic [15:0] col);
      fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = col;
   endtask

   // Asynchronous reset pulse: outputs must clear at once, no strobe right after release
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      chk({tag, " rst spi_inputs"}, spi_inputs, 0);
      chk({tag, " rst cmd strobe"}, spi_enable_command, 0);
      chk({tag, " rst par strobe"}, spi_enable_parameter, 0);
      chk({tag, " rst init_done"}, init_done, 0);
      chk({tag, " rst fill_ready"}, fill_ready, 0);
      chk({tag, " rst fill_err"}, fill_err, 0);
      chk({tag, " rst timeout_err"}, timeout_err, 0);
      repeat (3) @(negedge clk);
      #2 nrst = 1'b1;
      q.delete();
      @(negedge clk);
      chk({tag, " no strobe after release"},
          {spi_enable_command, spi_enable_parameter}, 0);
   endtask

   typedef struct {
      logic [8:0]  x0, x1, y0, y1;
      logic [15:0] color;
      logic        err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      bit ok;
      int fe0, n, qs;

      vecs[0] = '{9'd0,   9'd1,   9'd0,   9'd1,   16'hF800, 1'b0};
      vecs[1] = '{9'd5,   9'd4,   9'd0,   9'd0,   16'h1111, 1'b1};
      vecs[2] = '{9'd3,   9'd3,   9'd7,   9'd7,   16'h07E0, 1'b0};
      vecs[3] = '{9'd0,   9'd2,   9'd10,  9'd11,  16'h001F, 1'b0};
      vecs[4] = '{9'd511, 9'd511, 9'd511, 9'd511, 16'hFFFF, 1'b0};
      vecs[5] = '{9'd2,   9'd2,   9'd5,   9'd4,   16'h2222, 1'b1};
      vecs[6] = '{9'd10,  9'd13,  9'd0,   9'd0,   16'h1234, 1'b0};

      // Power-up sequence
      do_reset("init");
      chk("init fill_ready before done", fill_ready, 0);
      wait_init(1000, ok);
      chk("init_done reached", ok, 1);
      eq.delete();
      exp_init();
      compare_q("init");
      @(negedge clk);
      chk("fill_ready after init", fill_ready, 1);
      chk("timeout_err after init", timeout_err, 0);

      // Table-driven fills
      for (int i = 0; i < 7; i++) begin
         q.delete();
         eq.delete();
         fe0 = fill_err_pulses;
         chk($sformatf("vec%0d ready before", i), fill_ready, 1);
         set_fill(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].color);
         fill_valid = 1'b1;
         @(negedge clk);
         fill_valid = 1'b0;
         if (vecs[i].err) begin
            chk($sformatf("vec%0d fill_err pulse", i), fill_err, 1);
            @(negedge clk);
            chk($sformatf("vec%0d fill_err cleared", i), fill_err, 0);
            chk($sformatf("vec%0d ready returns", i), fill_ready, 1);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d no strobes", i), q.size(), 0);
            chk($sformatf("vec%0d single err pulse", i), fill_err_pulses - fe0, 1);
         end else begin
            chk($sformatf("vec%0d ready low in job", i), fill_ready, 0);
            chk($sformatf("vec%0d no fill_err", i), fill_err, 0);
            wait_ready(3000, ok);
            chk($sformatf("vec%0d job completes", i), ok, 1);
            exp_fill(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].color);
            compare_q($sformatf("vec%0d", i));
            chk($sformatf("vec%0d no err pulses", i), fill_err_pulses - fe0, 0);
         end
      end

      // fill_valid during a running job is dropped, not queued
      q.delete();
      eq.delete();
      set_fill(9'd0, 9'd0, 9'd0, 9'd1, 16'hABCD);
      fill_valid = 1'b1;
      @(negedge clk);
      fill_valid = 1'b0;
      repeat (30) @(negedge clk);
      set_fill(9'd4, 9'd6, 9'd4, 9'd6, 16'h5555);
      fill_valid = 1'b1;
      @(negedge clk);
      fill_valid = 1'b0;
      wait_ready(3000, ok);
      chk("ignore job completes", ok, 1);
      repeat (40) @(negedge clk);
      exp_fill(9'd0, 9'd0, 9'd0, 9'd1, 16'hABCD);
      compare_q("ignore");

      // Busy never rises after the CASET parameter
      q.delete();
      model_dead = 1'b1;
      set_fill(9'd1, 9'd2, 9'd1, 9'd2, 16'h0F0F);
      fill_valid = 1'b1;
      @(negedge clk);
      fill_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (q.size() >= 1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("timeout caset issued", ok, 1);
      n = 0;
      ok = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         n++;
         if (timeout_err) begin ok = 1'b1; break; end
      end
      chk("timeout_err set", ok, 1);
      chk("timeout latency window", (n >= 1024 && n <= 1026), 1);
      chk("timeout fill_ready", fill_ready, 0);
      chk("timeout init_done kept", init_done, 1);
      qs = q.size();
      set_fill(9'd0, 9'd0, 9'd0, 9'd0, 16'h0001);
      fill_valid = 1'b1;
      repeat (30) @(negedge clk);
      fill_valid = 1'b0;
      chk("timeout job dropped", q.size(), 1);
      chk("timeout no new strobes", q.size(), qs);
      chk("timeout_err sticky", timeout_err, 1);
      model_dead = 1'b0;

      // Reset in the middle of a 240x320 pixel stream
      do_reset("post-timeout");
      wait_init(1000, ok);
      chk("re-init done", ok, 1);
      set_fill(9'd0, 9'd239, 9'd0, 9'd319, 16'h8410);
      q.delete();
      fill_valid = 1'b1;
      @(negedge clk);
      fill_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (q.size() >= 6) begin ok = 1'b1; break; end
      end
      chk("big fill streaming", ok, 1);
      if (q.size() >= 4) chk("big fill write-continue", q[3].cmd, 8'h3C);
      do_reset("mid-stream");
      wait_init(1000, ok);
      chk("restart init done", ok, 1);
      eq.delete();
      exp_init();
      compare_q("restart");

`ifdef RAW_CMD_EN
      // Raw request beats a simultaneous fill request
      @(negedge clk);
      q.delete();
      eq.delete();
      raw_cmd = 8'h28; raw_cnt = 4'd0; raw_par = 32'h0;
      raw_valid = 1'b1;
      set_fill(9'd1, 9'd1, 9'd2, 9'd2, 16'h00FF);
      fill_valid = 1'b1;
      #1;
      chk("raw ready", raw_ready, 1);
      chk("fill blocked by raw", fill_ready, 0);
      @(negedge clk);
      raw_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 500; k++) begin
         if (fill_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("fill taken after raw", ok, 1);
      @(negedge clk);
      fill_valid = 1'b0;
      wait_ready(3000, ok);
      chk("raw+fill completes", ok, 1);
      push_exp(8'h28, 4'd0, 32'h0);
      exp_fill(9'd1, 9'd1, 9'd2, 9'd2, 16'h00FF);
      compare_q("raw");
`endif

      chk("command header upper bits zero", hdr_bad, 0);
      chk("parameter strobe without command", orphan, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
